reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//   Controller sitting behind the board clock/reset conditioning block. Takes the
//   design clock and conditioned reset, releases per-subsystem resets in a fixed
//   staged order (CPU, memory, peripherals...), and produces a divided clock enable.
//   Provides a soft-reset req/ack handshake that tears stages down in reverse order
//   and re-runs the release sequence.
// PARAMETERS
//   NUM_STAGES   4    number of sequenced reset domains (1..8)
//   HOLD_CYCLES  16   clk cycles between successive stage releases (>=2)
//   SLOW         0    clk_en divide exponent; clk_en pulses once per 2**SLOW cycles
//   WDT_WIDTH    20   watchdog counter width (used only with RSTSEQ_WDT_EN)
// PORTS
//   clk           in   1           design clock
//   resetn        in   1           asynchronous, active-low reset
//   soft_rst_req  in   1           level request for soft reset; held until ack
//   soft_rst_ack  out  1           one-cycle pulse: teardown complete
//   stage_resetn  out  NUM_STAGES  per-domain active-low resets; bit 0 released first
//   seq_done      out  1           high while all stages are released (RUN)
//   clk_en        out  1           divided clock enable
//   wdt_kick      in   1           watchdog clear (ignored without RSTSEQ_WDT_EN)
//   wdt_fired     out  1           one-cycle watchdog expiry pulse
// BEHAVIOUR
//   Reset (resetn=0, async): stage_resetn=0, seq_done=0, soft_rst_ack=0, clk_en=0,
//     wdt_fired=0; state=HOLD, hold_cnt=0, stage_idx=0, div_cnt=0, wdt_cnt=0.
//   FSM states: HOLD -> RUN -> DRAIN -> HOLD.
//   HOLD: hold_cnt increments every clk; on the edge where hold_cnt==HOLD_CYCLES-1,
//     set stage_resetn[stage_idx], stage_idx++, hold_cnt=0. Stage k goes high on the
//     (k+1)*HOLD_CYCLES-th rising edge after resetn deasserts. The edge releasing the
//     last stage also sets seq_done=1 and enters RUN.
//   RUN: stage_resetn all ones, seq_done=1. soft_rst_req=1 sampled -> next edge enters
//     DRAIN and clears stage_resetn[NUM_STAGES-1] and seq_done.
//   DRAIN: clear one stage per edge, highest index first. The edge clearing bit 0
//     asserts soft_rst_ack for exactly one cycle (software-initiated only) and
//     enters HOLD with hold_cnt=0, stage_idx=0. Teardown = NUM_STAGES edges.
//   Handshake: soft_rst_req sampled only in RUN; a request raised in HOLD/DRAIN is
//     pending, not dropped, and serviced on RUN entry. Requester drops req after ack;
//     req still high at next RUN entry triggers another soft reset.
//   clk_en: div_cnt (SLOW bits) free-runs in every state after reset; clk_en=1 on the
//     cycle div_cnt is all ones. SLOW=0 -> clk_en=1 every cycle after reset release.
//   Reset mid-operation: resetn low in any state forces reset values immediately,
//     no ack; sequence restarts from HOLD on deassertion.
// CONFIGURATION
//   RSTSEQ_WDT_EN defined: wdt_cnt counts each RUN cycle, cleared by wdt_kick or
//     outside RUN. When wdt_cnt reaches all ones: wdt_fired pulses one cycle and
//     the FSM enters DRAIN as for a soft reset, no soft_rst_ack. If soft_rst_req
//     and expiry coincide, soft reset wins: ack issued, no wdt_fired, wdt_cnt cleared.
//   RSTSEQ_WDT_EN undefined: no watchdog logic, wdt_kick ignored, wdt_fired tied 0.
// TESTING  (NUM_STAGES=4, HOLD_CYCLES=16, SLOW=2 unless stated)
//   1 Release resetn -> stage_resetn 0001@edge16, 0011@32, 0111@48, 1111 with
//     seq_done=1 @64; no change after.
//   2 Free run -> clk_en high exactly 1 cycle in 4; SLOW=0 build: clk_en const 1.
//   3 soft_rst_req=1 in RUN -> stage_resetn 0111,0011,0001,0000 on 4 successive
//     edges; soft_rst_ack pulses with 0000; drop req; 1111 again 64 edges later.
//   4 resetn low at edge 40 (stage 1 released) -> all outputs 0 without waiting
//     for clk; after release full 64-edge sequence from scratch.
//   5 soft_rst_req raised at edge 20 (HOLD) -> no ack/teardown before edge 64;
//     DRAIN starts edge 65, ack at edge 68.
//   6 RSTSEQ_WDT_EN, WDT_WIDTH=8: no kicks -> wdt_fired on 256th RUN edge, drain
//     without ack; kick every 100 cycles -> wdt_fired never asserts.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with soft-reset teardown handshake and divided clock enable.
// Optional watchdog forcing a teardown from RUN is built when RSTSEQ_WDT_EN is defined.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned SLOW        = 0,
    parameter int unsigned WDT_WIDTH   = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  seq_done,
    output logic                  clk_en,
    input  logic                  wdt_kick,
    output logic                  wdt_fired
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_d;
    logic [CNT_W-1:0]       hold_cnt;
    logic [CNT_W-1:0]       hold_cnt_d;
    logic [IDX_W-1:0]       stage_idx;
    logic [IDX_W-1:0]       stage_idx_d;
    logic [NUM_STAGES-1:0]  stage_resetn_d;
    logic                   seq_done_d;
    logic                   soft_rst_ack_d;
    logic                   wdt_fired_d;
    logic                   sw_drain;
    logic                   sw_drain_d;
    logic                   expire_c;

`ifdef RSTSEQ_WDT_EN
    logic [WDT_WIDTH-1:0] wdt_cnt;
    logic [WDT_WIDTH-1:0] wdt_cnt_d;

    // Counts RUN cycles since the last kick; leaving RUN clears it.
    always_comb begin
        wdt_cnt_d = '0;
        if (state == RUN && !wdt_kick) begin
            wdt_cnt_d = wdt_cnt + WDT_WIDTH'(1);
        end
    end

    assign expire_c = (state == RUN) && !wdt_kick && (&wdt_cnt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt_d;
        end
    end
`else
    logic unused_wdt;

    assign expire_c   = 1'b0;
    assign unused_wdt = ^{wdt_kick, 1'(WDT_WIDTH)};
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            stage_idx    <= '0;
            stage_resetn <= '0;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b0;
            wdt_fired    <= 1'b0;
            sw_drain     <= 1'b0;
        end else begin
            state        <= state_d;
            hold_cnt     <= hold_cnt_d;
            stage_idx    <= stage_idx_d;
            stage_resetn <= stage_resetn_d;
            seq_done     <= seq_done_d;
            soft_rst_ack <= soft_rst_ack_d;
            wdt_fired    <= wdt_fired_d;
            sw_drain     <= sw_drain_d;
        end
    end

    // stage_idx walks up during release and is left on the top stage so that
    // RUN and DRAIN share one teardown step, clearing bit stage_idx each edge.
    always_comb begin
        state_d        = state;
        hold_cnt_d     = hold_cnt;
        stage_idx_d    = stage_idx;
        stage_resetn_d = stage_resetn;
        sw_drain_d     = sw_drain;
        soft_rst_ack_d = 1'b0;
        wdt_fired_d    = 1'b0;

        case (state)
            HOLD: begin
                if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    hold_cnt_d     = '0;
                    stage_resetn_d = stage_resetn | (NUM_STAGES'(1) << stage_idx);
                    if (stage_idx == IDX_W'(NUM_STAGES - 1)) begin
                        state_d = RUN;
                    end else begin
                        stage_idx_d = stage_idx + IDX_W'(1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt + CNT_W'(1);
                end
            end

            RUN: begin
                if (soft_rst_req || expire_c) begin
                    sw_drain_d     = soft_rst_req;
                    wdt_fired_d    = !soft_rst_req;
                    stage_resetn_d = stage_resetn & ~(NUM_STAGES'(1) << stage_idx);
                    if (stage_idx == '0) begin
                        state_d        = HOLD;
                        hold_cnt_d     = '0;
                        soft_rst_ack_d = soft_rst_req;
                    end else begin
                        state_d     = DRAIN;
                        stage_idx_d = stage_idx - IDX_W'(1);
                    end
                end
            end

            DRAIN: begin
                stage_resetn_d = stage_resetn & ~(NUM_STAGES'(1) << stage_idx);
                if (stage_idx == '0) begin
                    state_d        = HOLD;
                    hold_cnt_d     = '0;
                    soft_rst_ack_d = sw_drain;
                end else begin
                    stage_idx_d = stage_idx - IDX_W'(1);
                end
            end

            default: begin
                state_d        = HOLD;
                hold_cnt_d     = '0;
                stage_idx_d    = '0;
                stage_resetn_d = '0;
            end
        endcase

        seq_done_d = (state_d == RUN);
    end

    // clk_en is high during the cycle in which the divider sits at all ones.
    if (SLOW > 0) begin : g_div
        logic [SLOW-1:0] div_cnt;
        logic [SLOW-1:0] div_nxt_c;

        assign div_nxt_c = div_cnt + SLOW'(1);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                div_cnt <= '0;
                clk_en  <= 1'b0;
            end else begin
                div_cnt <= div_nxt_c;
                clk_en  <= &div_nxt_c;
            end
        end
    end else begin : g_nodiv
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                clk_en <= 1'b0;
            end else begin
                clk_en <= 1'b1;
            end
        end
    end

endmodule
